gfx_cmd_ctrl: RTL and testbench
===============================

# gfx_cmd_ctrl

Command controller between the SPI receiver and the VGA display path. It buffers decoded SPI command frames (command plus two data bytes) in a small FIFO and executes them in order. Execution writes tiles to the display tile memory, runs full-board clears, and maintains score and game-state registers. Score and state are double-buffered so the VGA path only sees changes at frame boundaries, which prevents tearing.

## Interface
Parameters:
- ADDR_W, 10: tile memory address width
- CELLS, 768: number of valid tiles; must be ≤ 2^ADDR_W
- DATA_W, 4: tile value width; must be ≤ 4
- SCORE_W, 10: score width; SCORE_MAX = 2^SCORE_W-1
- STATE_W, 16: game-state width; must be ≤ 16
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥ 2

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command frame present (one-cycle strobe or held)
- cmd_ready  out  1  FIFO can accept; equals !full
- command  in  8  [7:4] opcode, [3:0] tile value
- databyte1  in  8  operand high byte
- databyte2  in  8  operand low byte
- frame_start  in  1  one-cycle pulse at start of vertical sync
- mem_we  out  1  tile memory write enable
- mem_waddr  out  ADDR_W  tile write address
- mem_wdata  out  DATA_W  tile write data
- score  out  SCORE_W  frame-stable score to the VGA path
- state  out  STATE_W  frame-stable game state to the VGA path
- busy  out  1  FIFO non-empty or executor not IDLE
- err  out  1  sticky error flag

## Operation
- Push: when cmd_valid && cmd_ready, store {command, databyte1, databyte2}. Frames offered while full are ignored; the source must hold them.
- Operand: op16 = {databyte1, databyte2}.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 WRITE_TILE: if op16 < CELLS, one write of addr = op16[ADDR_W-1:0] with data = command[DATA_W-1:0]. Otherwise no write and err is set.
  - 0x2 SET_SCORE: score_pend = min(op16, SCORE_MAX).
  - 0x3 ADD_SCORE: score_pend = min(score_pend + databyte2, SCORE_MAX). Use a widened add so the sum cannot wrap.
  - 0x4 SET_STATE: state_pend = op16[STATE_W-1:0].
  - 0x5 CLEAR: write command[DATA_W-1:0] to addresses 0..CELLS-1, one per cycle, ascending.
  - 0xF CLR_ERR: err = 0.
  - Any other opcode: discarded and err is set.
- FSM:
  - IDLE: if FIFO non-empty, pop and go to EXEC.
  - EXEC: perform the single-cycle action. Return to IDLE, or go to CLEAR for opcode 0x5.
  - CLEAR: count from 0 to CELLS-1, then return to IDLE.
  - The FIFO keeps accepting frames during CLEAR.
- Frame buffering: on frame_start, load score from score_pend and state from state_pend. If frame_start coincides with a pending update, the output takes the pre-update value and the new value appears at the next frame_start.
- err and CLR_ERR in the same cycle: CLR_ERR wins.
- Reset values: mem_we 0, mem_waddr 0, mem_wdata 0, score 0, state 0, score_pend 0, state_pend 0, err 0, busy 0, FIFO empty, FSM IDLE. cmd_ready is 1 once FIFO is empty.
- Reset during CLEAR or with FIFO contents: immediately abandon everything. Queued commands are lost and mem_we drops asynchronously.

## Timing
- Frame accepted at rising edge k into an empty FIFO while IDLE:
  - popped at edge k+1;
  - executed in the EXEC cycle, with mem_we registered high after edge k+2, for exactly one cycle;
  - score_pend and state_pend updated at edge k+2.
- Back-to-back commands sustain one command every 2 cycles (IDLE/EXEC).
- CLEAR asserts mem_we for exactly CELLS consecutive cycles, address 0 first. The first write appears after the edge that leaves EXEC.
- cmd_ready is combinational from the FIFO count and has no dependence on cmd_valid. Push and pop in the same cycle are both honoured.
- mem_* outputs are registered. mem_waddr and mem_wdata hold their last values when mem_we is 0.

## Configuration
- GFX_CLEAR_EN defined: opcode 0x5 performs CLEAR as described, and the CLEAR state and address counter are built.
- GFX_CLEAR_EN undefined: CLEAR state and counter are removed, and opcode 0x5 is treated as unknown (discarded, err set).

## Test plan
- Reset, then WRITE_TILE command=0x13, op16=0x0025 -> exactly one mem_we pulse with addr 0x025 and data 0x3, 2 cycles after accept; err stays 0.
- WRITE_TILE op16=0x0300 (CELLS=768) -> no mem_we and err=1. Then CLR_ERR (0xF0) -> err=0.
- SET_SCORE 0x03F0, then ADD_SCORE databyte2=0x20 -> score_pend=1023 (saturated). score stays 0 until frame_start, then reads 1023. frame_start in the same cycle as an update shows the old value.
- Hold cmd_valid with 6 queued frames during CLEAR -> cmd_ready drops after 4 accepts. Exactly 768 writes occur, addresses 0..767. Queued commands then run in order and busy falls afterwards.
- Assert reset_n low mid-CLEAR at address 100 -> mem_we drops immediately, score/state/err return to 0, FIFO is empty, and no writes occur after release.
- Build without GFX_CLEAR_EN and issue opcode 0x5 -> no writes and err=1.

Source files
------------

// File: rtl/gfx_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gfx_cmd_ctrl_if
// Description : Command-input handshake and tile-memory write bus of the
//               graphics command controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface gfx_cmd_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  // Command frame from the SPI receiver
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        command;
  logic [7:0]        databyte1;
  logic [7:0]        databyte2;
  // Tile memory write port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Command source and tile-memory sink
  modport master (
    output cmd_valid, command, databyte1, databyte2,
    input  cmd_ready, mem_we, mem_waddr, mem_wdata
  );

  // Controller side
  modport slave (
    input  cmd_valid, command, databyte1, databyte2,
    output cmd_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/gfx_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gfx_cmd_ctrl
// Description : Buffers SPI command frames in a FIFO and executes them in
//               order: tile writes, full-board clear, score and game-state
//               registers double-buffered to frame boundaries.
//               Optional feature macro: GFX_CLEAR_EN (builds the CLEAR state
//               and its address counter; without it opcode 0x5 is unknown).
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_cmd_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int CELLS      = 768,
  parameter int DATA_W     = 4,
  parameter int SCORE_W    = 10,
  parameter int STATE_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  gfx_cmd_ctrl_if.slave      bus,
  input  wire logic          frame_start,
  output logic [SCORE_W-1:0] score,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough for a 16-bit operand or score+byte without wrapping
  localparam int SUM_W = ((SCORE_W > 16) ? SCORE_W : 16) + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX_W = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_SET_SCORE = 4'h2;
  localparam logic [3:0] OP_ADD_SCORE = 4'h3;
  localparam logic [3:0] OP_SET_STATE = 4'h4;
`ifdef GFX_CLEAR_EN
  localparam logic [3:0] OP_CLEAR     = 4'h5;
`endif
  localparam logic [3:0] OP_CLR_ERR   = 4'hF;

`ifdef GFX_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_CLEAR = 2'd2} fsm_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1} fsm_t;
`endif

  fsm_t               fsm_q, fsm_d;
  logic [23:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [23:0]        cur_q, cur_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [SCORE_W-1:0] score_pend_q, score_pend_d, score_q, score_d;
  logic [STATE_W-1:0] state_pend_q, state_pend_d, state_q, state_d;
  logic               err_q, err_d;
`ifdef GFX_CLEAR_EN
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
`endif

  logic               fifo_full, fifo_empty, push, pop;
  logic [3:0]         opc;
  logic [DATA_W-1:0]  tile;
  logic [15:0]        op16;

  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign push          = bus.cmd_valid && !fifo_full;
  assign pop           = (fsm_q == ST_IDLE) && !fifo_empty;
  assign bus.cmd_ready = !fifo_full;
  assign opc           = cur_q[23:20];
  assign tile          = cur_q[16 +: DATA_W];
  assign op16          = cur_q[15:0];

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign score         = score_q;
  assign state         = state_q;
  assign err           = err_q;
  assign busy          = !fifo_empty || (fsm_q != ST_IDLE);

  function automatic logic [SCORE_W-1:0] sat(input logic [SUM_W-1:0] v);
    return (v > SCORE_MAX_W) ? {SCORE_W{1'b1}} : v[SCORE_W-1:0];
  endfunction

  // FIFO storage; contents are don't-care until the count says otherwise
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {bus.command, bus.databyte1, bus.databyte2};
  end

  // FIFO pointers/count and the popped command register
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    cur_d    = pop ? fifo_mem[rd_ptr_q] : cur_q;
  end

  // Executor next-state, write port, score/state/err and frame latching
  always_comb begin
    fsm_d        = fsm_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    score_pend_d = score_pend_q;
    state_pend_d = state_pend_q;
    err_d        = err_q;
`ifdef GFX_CLEAR_EN
    clr_cnt_d    = clr_cnt_q;
`endif
    // Outputs take the value pending before this edge's update
    score_d      = frame_start ? score_pend_q : score_q;
    state_d      = frame_start ? state_pend_q : state_q;

    case (fsm_q)
      ST_IDLE: begin
        if (!fifo_empty) fsm_d = ST_EXEC;
      end
      ST_EXEC: begin
        fsm_d = ST_IDLE;
        case (opc)
          OP_NOP: ;
          OP_WRITE: begin
            if ({16'd0, op16} < 32'(CELLS)) begin
              mem_we_d    = 1'b1;
              mem_waddr_d = op16[ADDR_W-1:0];
              mem_wdata_d = tile;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_SET_SCORE: score_pend_d = sat(SUM_W'(op16));
          OP_ADD_SCORE: score_pend_d = sat(SUM_W'(score_pend_q) + SUM_W'(op16[7:0]));
          OP_SET_STATE: state_pend_d = op16[STATE_W-1:0];
`ifdef GFX_CLEAR_EN
          OP_CLEAR: begin
            // Address 0 is written on leaving EXEC; CLEAR covers the rest
            mem_we_d    = 1'b1;
            mem_waddr_d = '0;
            mem_wdata_d = tile;
            if (CELLS > 1) begin
              fsm_d     = ST_CLEAR;
              clr_cnt_d = ADDR_W'(1);
            end
          end
`endif
          OP_CLR_ERR: err_d = 1'b0;
          default:    err_d = 1'b1;
        endcase
      end
`ifdef GFX_CLEAR_EN
      ST_CLEAR: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = clr_cnt_q;
        mem_wdata_d = tile;
        if (clr_cnt_q == ADDR_W'(CELLS - 1)) fsm_d = ST_IDLE;
        else clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
`endif
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons queued work and drops mem_we at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      score_pend_q <= '0;
      state_pend_q <= '0;
      score_q      <= '0;
      state_q      <= '0;
      err_q        <= 1'b0;
`ifdef GFX_CLEAR_EN
      clr_cnt_q    <= '0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_q        <= cur_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      score_pend_q <= score_pend_d;
      state_pend_q <= state_pend_d;
      score_q      <= score_d;
      state_q      <= state_d;
      err_q        <= err_d;
`ifdef GFX_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gfx_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_cmd_ctrl
// Description : Directed self-checking bench for gfx_cmd_ctrl. The CLEAR
//               checks are built when GFX_CLEAR_EN is defined; otherwise
//               opcode 0x5 is checked as an unknown opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  score;
  logic [15:0] state;
  logic        busy;
  logic        err;

  int n_asserts = 0;
  int n_fail    = 0;

  gfx_cmd_ctrl_if #(.ADDR_W(10), .DATA_W(4)) bus ();

  gfx_cmd_ctrl #(
    .ADDR_W(10), .CELLS(768), .DATA_W(4), .SCORE_W(10), .STATE_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .frame_start(frame_start),
    .score      (score),
    .state      (state),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle
  int unsigned wr_total = 0;
  logic [9:0]  wlog_addr [4096];
  logic [3:0]  wlog_data [4096];
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && wr_total < 4096) begin
      wlog_addr[wr_total] <= bus.mem_waddr;
      wlog_data[wr_total] <= bus.mem_wdata;
      wr_total            <= wr_total + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one frame for a single accepting edge (FIFO must have room)
  task automatic send(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
    bus.command   = c;
    bus.databyte1 = d1;
    bus.databyte2 = d2;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait2();
    tick();
    tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int unsigned n0;
    int unsigned n1;
    int guard;
    int acc;
    int bad_a;
    int bad_d;

    bus.cmd_valid = 1'b0;
    bus.command   = 8'h00;
    bus.databyte1 = 8'h00;
    bus.databyte2 = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_waddr", 32'(bus.mem_waddr), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    reset_n = 1'b1;
    tick();

    // WRITE_TILE 0x13, op16 0x0025: single write two edges after accept
    n0 = wr_total;
    send(8'h13, 8'h00, 8'h25);
    chk("wr_busy", 32'(busy), 1);
    tick();
    chk("wr_we_early", 32'(bus.mem_we), 0);
    tick();
    chk("wr_we", 32'(bus.mem_we), 1);
    chk("wr_addr", 32'(bus.mem_waddr), 32'h025);
    chk("wr_data", 32'(bus.mem_wdata), 32'h3);
    tick();
    chk("wr_we_off", 32'(bus.mem_we), 0);
    chk("wr_err", 32'(err), 0);
    chk("wr_idle", 32'(busy), 0);
    chk("wr_count", wr_total - n0, 1);

    // Out-of-range write sets err; CLR_ERR clears it
    n0 = wr_total;
    send(8'h10, 8'h03, 8'h00);
    wait2();
    chk("oor_err", 32'(err), 1);
    tick();
    chk("oor_nowrite", wr_total - n0, 0);
    send(8'hF0, 8'h00, 8'h00);
    wait2();
    chk("clr_err", 32'(err), 0);

    // Score saturation and frame buffering
    send(8'h20, 8'h03, 8'hF0);
    wait2();
    chk("score_hold", 32'(score), 0);
    send(8'h30, 8'h00, 8'h20);
    tick();
    frame();
    chk("score_coincide", 32'(score), 32'h3F0);
    frame();
    chk("score_sat_add", 32'(score), 32'h3FF);
    send(8'h20, 8'h00, 8'h05);
    wait2();
    frame();
    chk("score_set5", 32'(score), 5);
    send(8'h30, 8'h00, 8'hFF);
    wait2();
    frame();
    chk("score_add_ff", 32'(score), 32'h104);
    send(8'h20, 8'h12, 8'h34);
    wait2();
    frame();
    chk("score_sat_set", 32'(score), 32'h3FF);

    // Game state
    send(8'h40, 8'hAB, 8'hCD);
    wait2();
    chk("state_hold", 32'(state), 0);
    frame();
    chk("state_frame", 32'(state), 32'hABCD);

`ifndef GFX_CLEAR_EN
    // Opcode 0x5 without the clear feature is unknown
    n0 = wr_total;
    send(8'h55, 8'h00, 8'h00);
    wait2();
    tick();
    chk("op5_err", 32'(err), 1);
    chk("op5_nowrite", wr_total - n0, 0);
    send(8'hF0, 8'h00, 8'h00);
    wait2();
    chk("op5_clr_err", 32'(err), 0);
`endif

    // Six held frames (behind a CLEAR when built), then in-order execution
    n0 = wr_total;
`ifdef GFX_CLEAR_EN
    send(8'h57, 8'h00, 8'h00);
    wait2();
`endif
    acc = 0;
    for (int f = 0; f < 6; f++) begin
      bus.command   = 8'h10 | 8'(f + 1);
      bus.databyte1 = 8'h02;
      bus.databyte2 = 8'(f);
      bus.cmd_valid = 1'b1;
      guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 2000) begin
        tick();
        guard++;
      end
      chk("accept_timeout", 32'(guard < 2000), 1);
      tick();
      acc++;
`ifdef GFX_CLEAR_EN
      if (acc == 4) chk("ready_full", 32'(bus.cmd_ready), 0);
`endif
    end
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 3000) begin
      tick();
      guard++;
    end
    chk("busy_timeout", 32'(guard < 3000), 1);
    wait2();
`ifdef GFX_CLEAR_EN
    chk("clr_total", wr_total - n0, 768 + 6);
    bad_a = 0;
    bad_d = 0;
    for (int i = 0; i < 768; i++) begin
      if (wlog_addr[n0 + i] !== 10'(i)) bad_a++;
      if (wlog_data[n0 + i] !== 4'h7) bad_d++;
    end
    chk("clr_addr_seq", bad_a, 0);
    chk("clr_data", bad_d, 0);
    n0 = n0 + 768;
`else
    chk("q_total", wr_total - n0, 6);
`endif
    for (int f = 0; f < 6; f++) begin
      chk("q_addr", 32'(wlog_addr[n0 + f]), 32'h200 + f);
      chk("q_data", 32'(wlog_data[n0 + f]), f + 1);
    end
    chk("q_busy", 32'(busy), 0);

    // Reset with work in flight
    send(8'h60, 8'h00, 8'h00);
    wait2();
    chk("unk_err", 32'(err), 1);
`ifdef GFX_CLEAR_EN
    send(8'h52, 8'h00, 8'h00);
    send(8'h1A, 8'h00, 8'h05);
    guard = 0;
    while (!(bus.mem_we === 1'b1 && bus.mem_waddr === 10'd100) && guard < 2000) begin
      tick();
      guard++;
    end
`else
    bus.command   = 8'h1A;
    bus.databyte1 = 8'h00;
    bus.databyte2 = 8'h05;
    bus.cmd_valid = 1'b1;
    tick();
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (bus.mem_we !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
`endif
    chk("mid_timeout", 32'(guard < 2000), 1);
    chk("mid_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("ar_mem_we", 32'(bus.mem_we), 0);
    chk("ar_score", 32'(score), 0);
    chk("ar_state", 32'(state), 0);
    chk("ar_err", 32'(err), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ready", 32'(bus.cmd_ready), 1);
    n1 = wr_total;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("ar_nowrite", wr_total - n1, 0);
    chk("ar_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
